ftdi_row_parser: RTL

FTDI_ROW_PARSER -- requirements
Module: ftdi_row_parser

---
 rtl/ftdi_row_parser_if.sv | 27 ++
 rtl/ftdi_row_parser.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ftdi_row_parser_if.sv
// Byte-stream in / pixel-write out bundle for the FTDI row parser.
// No latency of its own; signals pass straight through the modports.
// Byte side has no backpressure; the source drives, the parser always accepts.
interface ftdi_row_parser_if #(
    parameter int ADDR_W = 11
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              pix_we;
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_data;
    logic              row_done;
    logic              frame_done;
    logic [7:0]        err_cnt;

    // Byte source / pixel sink side
    modport master (
        output byte_in, byte_valid,
        input  pix_we, pix_addr, pix_data, row_done, frame_done, err_cnt
    );

    // Parser side
    modport slave (
        input  byte_in, byte_valid,
        output pix_we, pix_addr, pix_data, row_done, frame_done, err_cnt
    );
endinterface

// File: rtl/ftdi_row_parser.sv
// Parses A5/row/RGB... packets from the FTDI byte stream into pixel RAM writes.
// Latency: pixel write one clock after its B byte; row/frame_done with the last write.
// No backpressure: every valid byte is consumed; stalled packets abort on idle timeout.
module ftdi_row_parser #(
    parameter int COLS    = 64,
    parameter int ROWS    = 32,
    parameter int TIMEOUT = 4096,
    parameter int ADDR_W  = 11
) (
    input  logic                clk_60,
    input  logic                rst,
    ftdi_row_parser_if.slave    bus
);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int IDLE_W = $clog2(TIMEOUT);

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] ROW  = 2'd1;
    localparam logic [1:0] PIX  = 2'd2;

    localparam logic [7:0] SYNC = 8'hA5;

    logic [1:0]        state;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [1:0]        phase;
    logic [7:0]        red;
    logic [7:0]        green;
    logic [IDLE_W-1:0] idle;

    logic [ADDR_W-1:0] addr_calc;
    logic [7:0]        err_next;
    logic              last_col;
    logic              timed_out;

    // Address of the pixel currently being assembled, saturated error count,
    // and the end-of-row / idle-expiry conditions
    always_comb begin
        addr_calc = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
        err_next  = (bus.err_cnt == 8'hFF) ? bus.err_cnt : bus.err_cnt + 8'd1;
        last_col  = (col == COL_W'(COLS - 1));
        timed_out = !bus.byte_valid && (idle == IDLE_W'(TIMEOUT - 1));
    end

    // Packet FSM, idle timer and registered pixel-write outputs
    always_ff @(posedge clk_60) begin
        if (rst) begin
            state          <= HUNT;
            row            <= '0;
            col            <= '0;
            phase          <= 2'd0;
            red            <= 8'd0;
            green          <= 8'd0;
            idle           <= '0;
            bus.pix_we     <= 1'b0;
            bus.pix_addr   <= '0;
            bus.pix_data   <= 24'd0;
            bus.row_done   <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.err_cnt    <= 8'd0;
        end else begin
            bus.pix_we     <= 1'b0;
            bus.row_done   <= 1'b0;
            bus.frame_done <= 1'b0;

            case (state)
                HUNT: begin
                    // Waiting for sync never expires; junk is dropped without error
                    idle <= '0;
                    if (bus.byte_valid && bus.byte_in == SYNC) begin
                        state <= ROW;
                    end
                end

                ROW: begin
                    if (bus.byte_valid) begin
                        idle <= '0;
                        if (32'(bus.byte_in) < ROWS) begin
                            row   <= bus.byte_in[ROW_W-1:0];
                            col   <= '0;
                            phase <= 2'd0;
                            state <= PIX;
                        end else begin
                            bus.err_cnt <= err_next;
                            state       <= HUNT;
                        end
                    end else if (timed_out) begin
                        bus.err_cnt <= err_next;
                        idle        <= '0;
                        state       <= HUNT;
                    end else begin
                        idle <= idle + 1'b1;
                    end
                end

                PIX: begin
                    // 0xA5 is ordinary colour data here, never a resync
                    if (bus.byte_valid) begin
                        idle <= '0;
                        case (phase)
                            2'd0: begin
                                red   <= bus.byte_in;
                                phase <= 2'd1;
                            end
                            2'd1: begin
                                green <= bus.byte_in;
                                phase <= 2'd2;
                            end
                            default: begin
                                bus.pix_we   <= 1'b1;
                                bus.pix_addr <= addr_calc;
                                bus.pix_data <= {red, green, bus.byte_in};
                                phase        <= 2'd0;
                                if (last_col) begin
                                    bus.row_done   <= 1'b1;
                                    bus.frame_done <= (row == ROW_W'(ROWS - 1));
                                    state          <= HUNT;
                                end else begin
                                    col <= col + 1'b1;
                                end
                            end
                        endcase
                    end else if (timed_out) begin
                        // Pixels already written stay; the row is simply abandoned
                        bus.err_cnt <= err_next;
                        idle        <= '0;
                        state       <= HUNT;
                    end else begin
                        idle <= idle + 1'b1;
                    end
                end

                default: begin
                    state <= HUNT;
                    idle  <= '0;
                end
            endcase
        end
    end
endmodule
